// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU word sequencer.
package alu_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    localparam int unsigned SLICE_WIDTH = 4;

    function automatic int unsigned slice_count(input int unsigned word_width);
        return word_width / SLICE_WIDTH;
    endfunction

endpackage

// File: rtl/alu_word_sequencer.sv
// Runs one WORD_WIDTH-bit operation through a single 4-bit parallel_ALU, one nibble per
// clock from the LSB, chaining the slice carry into Pin of the next pass.
module alu_word_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned SLICES     = slice_count(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] op_a,
    input  logic [WORD_WIDTH-1:0] op_b,
    input  logic [3:0]            op_s,
    input  logic                  op_m,
    input  logic                  op_cin,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  cout,
    output logic                  zero,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [3:0]            alu_s,
    output logic                  alu_m,
    output logic                  alu_pin,
    input  logic [3:0]            alu_r,
    input  logic [3:0]            alu_p
);

    localparam int unsigned IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    if ((WORD_WIDTH % SLICE_WIDTH) != 0 || WORD_WIDTH < SLICE_WIDTH) begin : g_bad_width
        $error("WORD_WIDTH must be a non-zero multiple of 4");
    end

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]            s_q, s_d;
    logic                  m_q, m_d, carry_q, carry_d;
    logic                  cout_q, cout_d, zero_q, zero_d, done_q, done_d;
    logic [31:0]           base;

    // Only the top bit of P carries information for the sequencer.
    logic unused_p;
    assign unused_p = ^alu_p[2:0];

    assign base    = 32'(idx_q) * SLICE_WIDTH;
    assign alu_a   = a_q[base +: SLICE_WIDTH];
    assign alu_b   = b_q[base +: SLICE_WIDTH];
    assign alu_s   = s_q;
    assign alu_m   = m_q;
    assign alu_pin = carry_q;

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    s_d     = op_s;
                    m_d     = op_m;
                    carry_d = op_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[base +: SLICE_WIDTH] = alu_r;
                carry_d = alu_p[3];
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end else begin
                    cout_d  = alu_p[3];
                    zero_d  = (result_d == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Self-checking bench: adder-stub ALU, word-level reference model, directed and random stimulus.
module tb_alu_word_sequencer;

    localparam int W = 16;
    localparam int SLICES = W / 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic [3:0]    op_s = '0;
    logic          op_m = 1'b0, op_cin = 1'b0;
    logic          busy, done, cout, zero;
    logic [W-1:0]  result;
    logic [3:0]    alu_a, alu_b, alu_s, alu_r, alu_p;
    logic          alu_m, alu_pin;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_word_sequencer #(.WORD_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_s(op_s),
        .op_m(op_m), .op_cin(op_cin), .busy(busy), .done(done), .result(result),
        .cout(cout), .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_m(alu_m), .alu_pin(alu_pin), .alu_r(alu_r), .alu_p(alu_p)
    );

    // Stub ALU: 4-bit add with carry in/out.
    logic [4:0] stub_sum;
    always_comb begin
        stub_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_pin};
        alu_r    = stub_sum[3:0];
        alu_p    = {stub_sum[4], 3'b000};
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level model: an accepted start yields the full-width sum SLICES edges later.
    int         m_rem = 0;
    logic [W:0] m_pend = '0;
    logic       exp_done = 1'b0, exp_cout = 1'b0, exp_zero = 1'b0;
    logic [W-1:0] exp_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem    <= 0;
            exp_done <= 1'b0;
            exp_res  <= '0;
            exp_cout <= 1'b0;
            exp_zero <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem  <= SLICES;
                    m_pend <= {1'b0, op_a} + {1'b0, op_b} + (W + 1)'(op_cin);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    exp_done <= 1'b1;
                    exp_res  <= m_pend[W-1:0];
                    exp_cout <= m_pend[W];
                    exp_zero <= (m_pend[W-1:0] == '0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_busy", busy, m_rem != 0);
            check("model_done", done, exp_done);
            if (exp_done) begin
                check("model_result", result, exp_res);
                check("model_cout", cout, exp_cout);
                check("model_zero", zero, exp_zero);
            end
        end
    end

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] er, input logic ec, input logic ez);
        int at;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; op_cin = cin;
        @(negedge clk);
        start = 1'b0;
        wait_done(12, at);
        check("op_result", result, er);
        check("op_cout", cout, ec);
        check("op_zero", zero, ez);
    endtask

    initial begin
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];
        logic [3:0] exp_pin;
        int t0, t1, t2, n_done;
        exp_a = '{4'hF, 4'hF, 4'h0, 4'h0};
        exp_b = '{4'h1, 4'h0, 4'h0, 4'h0};
        exp_pin = 4'b0110;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_zero", zero, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_pin", alu_pin, 0);
        rst = 1'b0;

        // Carry ripple with per-slice drive and exact latency.
        @(negedge clk);
        start = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; op_cin = 1'b0; op_s = 4'h9; op_m = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            op_s = 4'h0; op_m = 1'b0;
            check("ripple_alu_a", alu_a, exp_a[i]);
            check("ripple_alu_b", alu_b, exp_b[i]);
            check("ripple_alu_pin", alu_pin, exp_pin[i]);
            check("ripple_alu_s", alu_s, 4'h9);
            check("ripple_alu_m", alu_m, 1'b1);
        end
        @(negedge clk);
        check("ripple_done", done, 1);
        check("ripple_latency", cyc - t0, 5);
        check("ripple_result", result, 16'h0100);
        check("ripple_cout", cout, 0);
        check("ripple_zero", zero, 0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Ignored start and operand change while busy.
        @(negedge clk);
        start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_a = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        wait_done(12, t1);
        check("ignored_result", result, 16'h3333);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ignored_no_second_done", n_done, 0);
        check("ignored_idle", busy, 0);

        // Back-to-back with start held across done.
        @(negedge clk);
        start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
        @(negedge clk);
        op_a = 16'h0F0F; op_b = 16'h0101;
        wait_done(12, t1);
        check("b2b_first_result", result, 16'h3333);
        @(negedge clk);
        start = 1'b0;
        wait_done(12, t2);
        check("b2b_spacing", t2 - t1, 5);
        check("b2b_second_result", result, 16'h1010);

        // Asynchronous reset during slice 2.
        @(negedge clk);
        start = 1'b1; op_a = 16'h5555; op_b = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_cout", cout, 0);
        check("midrst_zero", zero, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);

        run_op(16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0);

        // Random traffic; the compare process checks every cycle against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 2) == 0);
            op_a   = W'($urandom);
            op_b   = ($urandom_range(0, 7) == 0) ? (~op_a + W'(1)) : W'($urandom);
            op_cin = 1'($urandom);
            op_s   = 4'($urandom);
            op_m   = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
